// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: default operand
// width, counter sizing helper and the FSM state encoding.
package serial_adder_pkg;

    localparam int WIDTH_DEF = 8;

    // Bit counter needs to address WIDTH bit positions; keep at least one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bit_slice_fa.sv
// Combinational 1-bit full adder used as the single arithmetic slice of the
// serial adder.
module bit_slice_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum is the three-input parity, carry is the three-input majority.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder slice processes the operands
// LSB first, one bit per clock, over WIDTH RUN cycles followed by a
// one-cycle DONE pulse.
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input that turns the
// operation into A-B (B inverted, carry-in forced to 1, cout=1 means no
// borrow).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int              CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cout_r;
    logic [WIDTH-1:0] b_cap;
    logic             c_cap;
    logic             accept;
    logic             fa_s;
    logic             fa_c;

    assign accept = (state == IDLE) && start;

    // Select what gets loaded into the B operand and carry registers on start.
    always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
        b_cap = sub ? ~b : b;
        c_cap = sub ? 1'b1 : cin;
`else
        b_cap = b;
        c_cap = cin;
`endif
    end

    // Single arithmetic slice, fed by the counter-selected operand bits.
    bit_slice_fa u_fa (
        .a    (a_r[cnt]),
        .b    (b_r[cnt]),
        .cin  (carry),
        .sum  (fa_s),
        .cout (fa_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: DONE always lasts one cycle and returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)       state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:                     state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Operand capture; operands are don't-care outside an operation.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r <= a;
            b_r <= b_cap;
        end
    end

    // Counter, carry and result accumulation; the counter holds on the last
    // bit instead of wrapping so it never aliases back into the operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            carry  <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            carry <= c_cap;
        end else if (state == RUN) begin
            sum_r[cnt] <= fa_s;
            carry      <= fa_c;
            if (cnt == LAST) cout_r <= fa_c;
            else             cnt    <= cnt + 1'b1;
        end
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed corner cases plus
// randomized operations compared against an arithmetic reference model.
// Honours SERIAL_ADDER_SUB_EN the same way as the design.
module tb_serial_adder_ctrl;

    localparam int W = 8;
`ifdef SERIAL_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_chk  = 0;
    int n_fail = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {cout,sum} of an unbounded-precision add truncated to W+1 bits.
    function automatic logic [W:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                         input logic tcin, input logic tsub);
        logic [W:0] r;
        if (tsub) r = {1'b0, ta} + {1'b0, ~tb} + (W+1)'(1);
        else      r = {1'b0, ta} + {1'b0, tb} + (W+1)'(tcin);
        return r;
    endfunction

    // Runs one operation starting from a negedge in IDLE.  inj>0 pulses start
    // with other operands in RUN cycle inj; rst_at>0 resets in RUN cycle rst_at.
    // Returns at the negedge of the first IDLE cycle after the operation.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                         input logic tsub, input int inj, input int rst_at);
        logic [W:0] exp;
        int         ndone;
        int         dn_n;
        logic [W-1:0] s_at_done;
        logic       c_at_done;
        exp = model(ta, tb, tcin, tsub);
        ndone = 0;
        dn_n = 0;
        s_at_done = '0;
        c_at_done = 1'b0;
        a = ta; b = tb; cin = tcin; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub = tsub;
`endif
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (rst_at > 0) begin
            for (int n = 1; n < rst_at; n++) begin
                chk("busy_run", 32'(busy), 32'(1));
                @(negedge clk);
            end
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("rst_busy", 32'(busy), 32'(0));
            chk("rst_done", 32'(done), 32'(0));
            chk("rst_sum",  32'(sum),  32'(0));
            chk("rst_cout", 32'(cout), 32'(0));
            for (int n = 0; n < W + 2; n++) begin
                if (done) ndone++;
                @(negedge clk);
            end
            chk("rst_no_done", 32'(ndone), 32'(0));
            chk("rst_idle", 32'(busy), 32'(0));
        end else begin
            for (int n = 1; n <= W + 1; n++) begin
                if (n == inj) begin
                    start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
                end else begin
                    start = 1'b0;
                end
                chk("busy_op", 32'(busy), 32'(1));
                if (done) begin
                    ndone++;
                    dn_n = n;
                    s_at_done = sum;
                    c_at_done = cout;
                end
                @(negedge clk);
            end
            start = 1'b0;
            chk("done_count", 32'(ndone), 32'(1));
            chk("latency",    32'(dn_n),  32'(W + 1));
            chk("sum",        32'(s_at_done), 32'(exp[W-1:0]));
            chk("cout",       32'(c_at_done), 32'(exp[W]));
            chk("idle_busy",  32'(busy), 32'(0));
            chk("idle_done",  32'(done), 32'(0));
            chk("sum_hold",   32'(sum),  32'(exp[W-1:0]));
            chk("cout_hold",  32'(cout), 32'(exp[W]));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_done", 32'(done), 32'(0));
        chk("reset_sum",  32'(sum),  32'(0));
        chk("reset_cout", 32'(cout), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // Basic add, latency and carry propagation through low nibble.
        do_op(8'h0F, 8'h01, 1'b0, 1'b0, 0, 0);
        // Full-width carry-out, then back-to-back start in the next IDLE cycle.
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 0);
        do_op(8'h7F, 8'h00, 1'b1, 1'b0, 0, 0);
        // Start pulse during RUN must not disturb the operation.
        do_op(8'h12, 8'h34, 1'b0, 1'b0, 3, 0);
        // Reset mid-operation aborts it; a fresh operation then completes.
        do_op(8'h3C, 8'h5A, 1'b1, 1'b0, 0, 4);
        do_op(8'h81, 8'h81, 1'b1, 1'b0, 0, 0);
        if (SUB_EN) begin
            do_op(8'h05, 8'h07, 1'b0, 1'b1, 0, 0);
            do_op(8'h07, 8'h05, 1'b0, 1'b1, 0, 0);
        end

        // Randomized operations with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            logic         rs;
            int           gap;
            ra  = W'($urandom);
            rb  = W'($urandom);
            rc  = 1'($urandom);
            rs  = SUB_EN ? 1'($urandom) : 1'b0;
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
            do_op(ra, rb, rc, rs, (i % 5 == 2) ? int'($urandom_range(1, W)) : 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
